// File: rtl/status_unit_if.sv
// Bus between the program-flow front end and the status unit: ALU flags,
// program-flow op handshake, return-from-trap, status and jump decision.
interface status_unit_if;
    logic       alu_valid;
    logic       alu_zero;
    logic       alu_sign;
    logic       alu_carry;
    logic       op_valid;
    logic [2:0] op;
    logic [2:0] sr_data;
    logic       rti;
    logic       op_ready;
    logic [3:0] status;
    logic       jump_valid;
    logic       jump_taken;

    modport master (
        output alu_valid, alu_zero, alu_sign, alu_carry,
        output op_valid, op, sr_data, rti,
        input  op_ready, status, jump_valid, jump_taken
    );

    modport slave (
        input  alu_valid, alu_zero, alu_sign, alu_carry,
        input  op_valid, op, sr_data, rti,
        output op_ready, status, jump_valid, jump_taken
    );
endinterface

// File: rtl/status_unit.sv
// Status register unit: holds {carry,sign,zero} flags, resolves conditional
// jumps against them and sequences trap entry / exit with a shadow copy.
module status_unit #(
    parameter int TRAP_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    status_unit_if.slave   bus
);
    localparam logic [2:0] OP_JMP   = 3'b001;
    localparam logic [2:0] OP_JZ    = 3'b010;
    localparam logic [2:0] OP_JS    = 3'b011;
    localparam logic [2:0] OP_JZS   = 3'b100;
    localparam logic [2:0] OP_LDSR  = 3'b101;
    localparam logic [2:0] OP_XORSR = 3'b110;
    localparam logic [2:0] OP_TRAP  = 3'b111;

    // Counter is loaded with TRAP_CYCLES-1 so the entry state lasts exactly
    // TRAP_CYCLES cycles, leaving when the count has reached zero.
    localparam logic [3:0] CNT_INIT = 4'(TRAP_CYCLES - 1);

    typedef enum logic [1:0] {S_RUN, S_TRAP_ENTRY, S_TRAP, S_TRAP_EXIT} state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_flags;
    logic [2:0] r_shadow;
    logic [3:0] r_cnt;
    logic       r_jump_valid;
    logic       r_jump_taken;

    logic w_op_state;
    logic w_rti;
    logic w_op_fire;
    logic w_trap_go;
    logic w_is_jump;
    logic w_cond;

    assign w_op_state = (r_state == S_RUN) || (r_state == S_TRAP);
    // rti only counts in TRAP and then overrides any op or ALU update
    assign w_rti      = bus.rti && (r_state == S_TRAP);
    assign w_op_fire  = bus.op_valid && w_op_state && !w_rti;
    // a TRAP op in TRAP is a NOP: only RUN starts a trap
    assign w_trap_go  = w_op_fire && (bus.op == OP_TRAP) && (r_state == S_RUN);
    assign w_is_jump  = (bus.op == OP_JMP) || (bus.op == OP_JZ) ||
                        (bus.op == OP_JS)  || (bus.op == OP_JZS);

    // Jump condition from the flags held before this edge
    always_comb begin
        w_cond = 1'b0;
        case (bus.op)
            OP_JMP:  w_cond = 1'b1;
            OP_JZ:   w_cond = r_flags[0];
            OP_JS:   w_cond = r_flags[1];
            OP_JZS:  w_cond = r_flags[0] | r_flags[1];
            default: w_cond = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:        if (w_trap_go)     w_state_nxt = S_TRAP_ENTRY;
            S_TRAP_ENTRY: if (r_cnt == 4'd0) w_state_nxt = S_TRAP;
            S_TRAP:       if (w_rti)         w_state_nxt = S_TRAP_EXIT;
            S_TRAP_EXIT:                     w_state_nxt = S_RUN;
            default:                         w_state_nxt = S_RUN;
        endcase
    end

    // Flags and shadow: restore > trap entry > LDSR/XORSR > ALU update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags  <= 3'b000;
            r_shadow <= 3'b000;
        end else if (r_state == S_TRAP_EXIT) begin
            r_flags  <= r_shadow;
        end else if (w_trap_go) begin
            r_shadow <= r_flags;
            r_flags  <= 3'b000;
        end else if (w_op_fire && (bus.op == OP_LDSR)) begin
            r_flags  <= bus.sr_data;
        end else if (w_op_fire && (bus.op == OP_XORSR)) begin
            r_flags  <= r_flags ^ bus.sr_data;
        end else if (bus.alu_valid && w_op_state && !w_rti) begin
            r_flags  <= {bus.alu_carry, bus.alu_sign, bus.alu_zero};
        end
    end

    // Trap-entry down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_cnt <= 4'd0;
        else if (w_trap_go)                              r_cnt <= CNT_INIT;
        else if (r_state == S_TRAP_ENTRY && r_cnt != 0)  r_cnt <= r_cnt - 4'd1;
    end

    // One-cycle jump decision pulse; taken is forced low outside the pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jump_valid <= 1'b0;
            r_jump_taken <= 1'b0;
        end else begin
            r_jump_valid <= w_op_fire && w_is_jump;
            r_jump_taken <= w_op_fire && w_is_jump && w_cond;
        end
    end

    assign bus.op_ready   = w_op_state;
    assign bus.status     = {(r_state == S_TRAP_ENTRY) || (r_state == S_TRAP), r_flags};
    assign bus.jump_valid = r_jump_valid;
    assign bus.jump_taken = r_jump_taken;
endmodule

// File: tb/tb_status_unit.sv
// Scoreboard bench for status_unit: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares after every clock edge.
module tb_status_unit;
    localparam int TC = 4;

    logic clk;
    logic rst;
    status_unit_if bus();

    status_unit #(.TRAP_CYCLES(TC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] status;
        logic       rdy;
        logic       jv;
    } exp_t;

    exp_t exp_q[$];
    bit   jq[$];
    int   checks   = 0;
    int   failures = 0;

    // reference model: mode 0 run, 1 entering trap, 2 in trap, 3 leaving trap
    int       m_mode;
    int       m_busy;
    bit [2:0] m_flags;
    bit [2:0] m_shadow;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per clock edge, jump outcomes from their own queue
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("status", bus.status, e.status);
            chk("op_ready", {3'b0, bus.op_ready}, {3'b0, e.rdy});
            chk("jump_valid", {3'b0, bus.jump_valid}, {3'b0, e.jv});
            if (bus.jump_valid) begin
                if (jq.size() == 0) begin
                    chk("jump_unexpected", 4'd1, 4'd0);
                end else begin
                    bit t;
                    t = jq.pop_front();
                    chk("jump_taken", {3'b0, bus.jump_taken}, {3'b0, t});
                end
            end else begin
                chk("jump_taken_idle", {3'b0, bus.jump_taken}, 4'd0);
            end
        end
    end

    function automatic void model_reset();
        m_mode = 0; m_busy = 0; m_flags = 3'b000; m_shadow = 3'b000;
    endfunction

    task automatic cyc(input bit av, input bit z, input bit s, input bit c,
                       input bit ov, input bit [2:0] op, input bit [2:0] sr, input bit r);
        bit ready, rtiw, fire, jv, jt;
        exp_t e;
        @(negedge clk);
        bus.alu_valid = av; bus.alu_zero = z; bus.alu_sign = s; bus.alu_carry = c;
        bus.op_valid = ov; bus.op = op; bus.sr_data = sr; bus.rti = r;

        ready = (m_mode == 0) || (m_mode == 2);
        rtiw  = r && (m_mode == 2);
        fire  = ov && ready && !rtiw;
        jv    = fire && (op >= 3'd1) && (op <= 3'd4);
        jt    = jv && ((op == 3'd1) || (op == 3'd2 && m_flags[0]) ||
                       (op == 3'd3 && m_flags[1]) ||
                       (op == 3'd4 && (m_flags[0] || m_flags[1])));
        if (jv) jq.push_back(jt);

        if (m_mode == 1) begin
            m_busy--;
            if (m_busy == 0) m_mode = 2;
        end else if (m_mode == 3) begin
            m_flags = m_shadow;
            m_mode  = 0;
        end else if (rtiw) begin
            m_mode = 3;
        end else if (m_mode == 0 && fire && op == 3'd7) begin
            m_shadow = m_flags;
            m_flags  = 3'b000;
            m_mode   = 1;
            m_busy   = TC;
        end else if (fire && op == 3'd5) begin
            m_flags = sr;
        end else if (fire && op == 3'd6) begin
            m_flags = m_flags ^ sr;
        end else if (av) begin
            m_flags = {c, s, z};
        end

        e.status = {(m_mode == 1 || m_mode == 2), m_flags};
        e.rdy    = (m_mode == 0) || (m_mode == 2);
        e.jv     = jv;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 3'd0, 3'd0, 0);
    endtask

    task automatic op1(input bit [2:0] op, input bit [2:0] sr);
        cyc(0, 0, 0, 0, 1, op, sr, 0);
    endtask

    // Asynchronous reset applied mid-cycle and checked before any edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.op_valid = 1'b0; bus.alu_valid = 1'b0; bus.rti = 1'b0;
        #1;
        chk("reset_status", bus.status, 4'b0000);
        chk("reset_op_ready", {3'b0, bus.op_ready}, 4'd1);
        chk("reset_jump", {2'b0, bus.jump_valid, bus.jump_taken}, 4'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.alu_valid = 0; bus.alu_zero = 0; bus.alu_sign = 0; bus.alu_carry = 0;
        bus.op_valid = 0; bus.op = 3'd0; bus.sr_data = 3'd0; bus.rti = 0;
        model_reset();
        #1;
        chk("por_status", bus.status, 4'b0000);
        chk("por_op_ready", {3'b0, bus.op_ready}, 4'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // ALU flags z=1,c=1 then JZ: status 0101, JZ taken
        cyc(1, 1, 0, 1, 0, 3'd0, 3'd0, 0);
        op1(3'd2, 3'd0);
        idle(2);
        // XORSR beats coincident ALU flags: 0010 ^ 011 = 0001
        op1(3'd5, 3'b010);
        cyc(1, 0, 0, 0, 1, 3'd6, 3'b011, 0);
        idle(1);
        // trap entry / exit with status 0110
        op1(3'd5, 3'b110);
        op1(3'd7, 3'd0);
        idle(6);
        cyc(0, 0, 0, 0, 0, 3'd0, 3'd0, 1);
        idle(3);
        // rti with LDSR 111 in TRAP: LDSR dropped, shadow restored
        op1(3'd5, 3'b101);
        op1(3'd7, 3'd0);
        idle(5);
        op1(3'd7, 3'd0);                       // nested trap is a NOP
        cyc(1, 0, 1, 0, 0, 3'd0, 3'd0, 0);     // ALU updates in TRAP
        cyc(1, 1, 1, 1, 1, 3'd5, 3'b111, 1);
        idle(3);
        // jump conditions
        op1(3'd5, 3'b000);
        op1(3'd4, 3'd0);
        op1(3'd5, 3'b010);
        op1(3'd4, 3'd0);
        op1(3'd1, 3'd0);
        op1(3'd3, 3'd0);
        op1(3'd2, 3'd0);
        cyc(0, 0, 0, 0, 0, 3'd5, 3'b111, 1);   // op_valid=0, rti outside TRAP
        idle(2);
        // reset two cycles into trap entry, then a fresh trap
        op1(3'd5, 3'b011);
        op1(3'd7, 3'd0);
        idle(2);
        do_reset();
        op1(3'd7, 3'd0);
        idle(6);
        cyc(0, 0, 0, 0, 0, 3'd0, 3'd0, 1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit [2:0] rop;
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd7 && $urandom_range(0, 3) != 0) rop = 3'd0;
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), rop, 3'($urandom), ($urandom_range(0, 7) == 0));
        end
        idle(3);
        @(posedge clk); #2;
        chk("jump_queue_drained", 4'(jq.size()), 4'd0);
        chk("exp_queue_drained", 4'(exp_q.size()), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
